// File: rtl/instr_buffer.sv
// Circular instruction queue between fetch and pre-decode: compacts masked fetch lanes
// into program order and presents the oldest DECODE_WIDTH entries combinationally.
module instr_buffer #(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [FETCH_WIDTH-1:0]    fetch_mask,
  input  logic [FETCH_WIDTH*32-1:0] fetch_instr,
  input  logic [FETCH_WIDTH*32-1:0] fetch_pc,
  output logic [DECODE_WIDTH-1:0]   dec_valid,
  output logic [DECODE_WIDTH*32-1:0] dec_instr,
  output logic [DECODE_WIDTH*32-1:0] dec_pc,
  input  logic                      dec_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] wr_num;
  logic [CW-1:0] rd_num;
  logic [PW-1:0] lane_off [FETCH_WIDTH];
  logic          wr_fire;
  logic          rd_fire;

  // Each set lane lands at tail plus the number of set lanes below it.
  always_comb begin
    wr_num = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_off[i] = wr_num[PW-1:0];
      if (fetch_mask[i]) wr_num = wr_num + CW'(1);
    end
  end

  assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
  assign wr_fire     = fetch_valid && fetch_ready && !flush;
  assign rd_fire     = dec_ready && !flush;
  assign rd_num      = (count_q < CW'(DECODE_WIDTH)) ? count_q : CW'(DECODE_WIDTH);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_fire) tail_d = tail_q + wr_num[PW-1:0];
      if (rd_fire) head_d = head_q + rd_num[PW-1:0];
      count_d = count_q + (wr_fire ? wr_num : '0) - (rd_fire ? rd_num : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_fire && fetch_mask[i]) begin
        instr_q[tail_q + lane_off[i]] <= fetch_instr[32*i +: 32];
        pc_q[tail_q + lane_off[i]]    <= fetch_pc[32*i +: 32];
      end
    end
  end

  always_comb begin
    dec_valid = '0;
    dec_instr = '0;
    dec_pc    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (count_q > CW'(j)) begin
        dec_valid[j]        = 1'b1;
        dec_instr[32*j +: 32] = instr_q[head_q + PW'(j)];
        dec_pc[32*j +: 32]    = pc_q[head_q + PW'(j)];
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with flushes and resets.
module tb_instr_buffer;
  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int DW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, fetch_valid, fetch_ready, dec_ready;
  logic [FW-1:0]     fetch_mask;
  logic [FW*32-1:0]  fetch_instr, fetch_pc;
  logic [DW-1:0]     dec_valid;
  logic [DW*32-1:0]  dec_instr, dec_pc;
  logic [4:0]        count;

  instr_buffer #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_mask(fetch_mask), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready), .count(count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mq[$];   // {pc, instr}, oldest at front
  bit started = 1'b0;
  bit wrap_chk = 1'b0;
  logic [31:0] wrap_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return (DEPTH - mq.size()) >= FW;
  endfunction

  task automatic cycle();
    logic [DW-1:0]    ev;
    logic [DW*32-1:0] ei, ep;
    bit rdy;
    int rn;
    @(negedge clk);
    if (started) begin
      ev = '0; ei = '0; ep = '0;
      for (int j = 0; j < DW; j++) begin
        if (j < mq.size()) begin
          ev[j] = 1'b1;
          ei[32*j +: 32] = mq[j][31:0];
          ep[32*j +: 32] = mq[j][63:32];
        end
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("fetch_ready", 64'(fetch_ready), 64'(model_ready()));
      chk("dec_valid", 64'(dec_valid), 64'(ev));
      chk("dec_instr", 64'(dec_instr), 64'(ei));
      chk("dec_pc", 64'(dec_pc), 64'(ep));
      if (wrap_chk && dec_ready && !flush && !rst) begin
        for (int j = 0; j < DW; j++) begin
          if (dec_valid[j]) begin
            chk("wrap_order", 64'(dec_instr[32*j +: 32]), 64'(wrap_seq));
            wrap_seq = wrap_seq + 1;
          end
        end
      end
    end
    if (rst || flush) begin
      mq.delete();
    end else begin
      rdy = model_ready();
      if (dec_ready) begin
        rn = (mq.size() < DW) ? mq.size() : DW;
        repeat (rn) void'(mq.pop_front());
      end
      if (fetch_valid && rdy) begin
        for (int i = 0; i < FW; i++)
          if (fetch_mask[i]) mq.push_back({fetch_pc[32*i +: 32], fetch_instr[32*i +: 32]});
      end
    end
    @(posedge clk);
    #1;
    started = 1'b1;
  endtask

  task automatic set_pkt(input logic [FW-1:0] m, input logic [31:0] ibase, input logic [31:0] pbase);
    fetch_valid = 1'b1;
    fetch_mask  = m;
    for (int i = 0; i < FW; i++) begin
      fetch_instr[32*i +: 32] = ibase + 32'(i);
      fetch_pc[32*i +: 32]    = pbase + 32'(4*i);
    end
  endtask

  initial begin
    int src;
    bit acc;
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    set_pkt(4'b1111, 32'hDEAD0000, 32'h0);
    cycle(); cycle();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    rst = 1'b0;

    // Basic flow
    fetch_valid = 1'b1; fetch_mask = 4'b1111;
    fetch_instr = {32'h44, 32'h33, 32'h22, 32'h11};
    fetch_pc    = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
    cycle();
    fetch_valid = 1'b0;
    chk("basic_valid", 64'(dec_valid), 64'h3);
    chk("basic_instr", 64'(dec_instr), {32'h22, 32'h11});
    chk("basic_pc", 64'(dec_pc), {32'h1004, 32'h1000});
    chk("basic_count", 64'(count), 64'd4);
    dec_ready = 1'b1;
    cycle();
    chk("basic_instr2", 64'(dec_instr), {32'h44, 32'h33});
    cycle();
    chk("basic_drain", 64'(count), 64'd0);
    dec_ready = 1'b0;

    // Sparse mask
    fetch_valid = 1'b1; fetch_mask = 4'b1010;
    fetch_instr = {32'hD, 32'hC, 32'hB, 32'hA};
    fetch_pc    = {32'h200C, 32'h2008, 32'h2004, 32'h2000};
    cycle();
    fetch_valid = 1'b0;
    chk("sparse_count", 64'(count), 64'd2);
    chk("sparse_instr", 64'(dec_instr), {32'hD, 32'hB});
    chk("sparse_pc", 64'(dec_pc), {32'h200C, 32'h2004});
    dec_ready = 1'b1; cycle(); dec_ready = 1'b0;

    // Full / backpressure
    for (int p = 0; p < 4; p++) begin
      set_pkt(4'b1111, 32'h300 + 32'(4*p), 32'h3000 + 32'(16*p));
      cycle();
    end
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    set_pkt(4'b1111, 32'h999, 32'h9990);
    cycle();
    chk("held_count", 64'(count), 64'd16);
    fetch_valid = 1'b0; dec_ready = 1'b1;
    cycle();
    chk("rd1_count", 64'(count), 64'd14);
    chk("rd1_ready", 64'(fetch_ready), 64'd0);
    cycle();
    chk("rd2_count", 64'(count), 64'd12);
    chk("rd2_ready", 64'(fetch_ready), 64'd1);
    chk("rd2_instr", 64'(dec_instr), {32'h305, 32'h304});
    repeat (6) cycle();
    dec_ready = 1'b0;

    // Wrap with simultaneous traffic
    wrap_chk = 1'b1; wrap_seq = 32'h100; src = 0;
    dec_ready = 1'b1;
    for (int c = 0; c < 200 && wrap_seq < 32'h100 + 40; c++) begin
      if (src < 40 && model_ready()) set_pkt(4'b1111, 32'h100 + 32'(src), 32'h4000 + 32'(4*src));
      else fetch_valid = 1'b0;
      acc = fetch_valid && model_ready();
      cycle();
      if (acc) src += 4;
    end
    wrap_chk = 1'b0;
    chk("wrap_total", 64'(wrap_seq), 64'h100 + 64'd40);
    chk("wrap_empty", 64'(count), 64'd0);
    dec_ready = 1'b0;

    // Flush
    set_pkt(4'b1111, 32'h500, 32'h5000); cycle();
    set_pkt(4'b1111, 32'h504, 32'h5010); cycle();
    set_pkt(4'b0011, 32'h508, 32'h5020); cycle();
    chk("pre_flush_count", 64'(count), 64'd10);
    flush = 1'b1; dec_ready = 1'b1;
    set_pkt(4'b1111, 32'h600, 32'h6000);
    cycle();
    flush = 1'b0; dec_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    set_pkt(4'b1111, 32'h700, 32'h7000);
    cycle();
    fetch_valid = 1'b0;
    chk("post_flush_lane0", 64'(dec_instr[31:0]), 64'h700);
    chk("post_flush_pc0", 64'(dec_pc[31:0]), 64'h7000);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_mask  = FW'($urandom);
      dec_ready   = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < FW; i++) begin
        fetch_instr[32*i +: 32] = $urandom;
        fetch_pc[32*i +: 32]    = $urandom;
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b1;
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
